bit_slice_transmitter: RTL and testbench

Transmitter side of the bit-serial summation link. Holds M operands of N bits each and streams them out transposed, one bit-slice per clock: slice k carries bit k of every operand, LSB slice first, in a free-running frame of N cycles aligned to reset release. It is the source that feeds the parallel accumulating adder. That adder counts its own frame from reset, so this block keeps the same frame phase and changes operands only on frame boundaries.

---
 rtl/bit_slice_transmitter_pkg.sv | 20 ++
 rtl/bit_slice_transmitter_if.sv | 34 +++
 rtl/bit_slice_transmitter_mux.sv | 24 ++
 rtl/bit_slice_transmitter.sv | 73 +++++++
 tb/tb_bit_slice_transmitter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_slice_transmitter_pkg.sv
// Shared definitions for the bit-serial summation link (transmitter, adder, bench).
// Holds default operand count/width, index-width derivations and index typedefs.
// No logic; a clog2 helper clamps to 1 so degenerate sizes still give legal widths.
package bit_slice_transmitter_pkg;

  localparam int DEF_M = 32;  // operands per slice
  localparam int DEF_N = 32;  // operand width = frame length in cycles

  // clog2 that never returns 0, so a 1-wide index is still a legal vector
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int DEF_IW = clog2_min1(DEF_N);
  localparam int DEF_AW = clog2_min1(DEF_M);

  typedef logic [DEF_IW-1:0] slice_idx_t;
  typedef logic [DEF_AW-1:0] word_addr_t;

endpackage

// File: rtl/bit_slice_transmitter_if.sv
// Bus between the operand writer and the bit-slice transmitter.
// master: drives writes/commit, observes slices; slave: the transmitter.
// Ports: wr_en/wr_addr/wr_data/commit in, data_bits/slice_idx/frame_start/commit_pending/commit_ack out.
interface bit_slice_transmitter_if
  import bit_slice_transmitter_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N
) ();

  localparam int IW = clog2_min1(N);
  localparam int AW = clog2_min1(M);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          commit;
  logic [M-1:0]  data_bits;
  logic [IW-1:0] slice_idx;
  logic          frame_start;
  logic          commit_pending;
  logic          commit_ack;

  modport master (
    output wr_en, wr_addr, wr_data, commit,
    input  data_bits, slice_idx, frame_start, commit_pending, commit_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit,
    output data_bits, slice_idx, frame_start, commit_pending, commit_ack
  );

endinterface

// File: rtl/bit_slice_transmitter_mux.sv
// Transposing slice selector: bits[j] = bit idx of word j.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: words (M x N active bank), idx (slice index) in; bits (M-bit slice) out.
module bit_slice_mux
  import bit_slice_transmitter_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N,
  localparam int IW = clog2_min1(N)
) (
  input  logic [M-1:0][N-1:0] words,
  input  logic [IW-1:0]       idx,
  output logic [M-1:0]        bits
);

  always_comb begin
    bits = '0;
    for (int j = 0; j < M; j++) begin
      bits[j] = words[j][idx];
    end
  end

endmodule

// File: rtl/bit_slice_transmitter.sv
// Streams M staged operands out transposed, one bit-slice per clock, LSB slice first.
// Latency: slice visible the cycle the counter reaches it; commit lands at next frame boundary.
// Backpressure: none; the N-cycle frame free-runs from reset release and never stalls.
// Ports: clk, rst (sync, active high); bus (slave modport) carries writes, commit and slice outputs.
module bit_slice_transmitter
  import bit_slice_transmitter_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N   // power of two: the slice counter wraps by overflow
) (
  input  logic                   clk,
  input  logic                   rst,
  bit_slice_transmitter_if.slave bus
);

  localparam int IW = clog2_min1(N);
  localparam int AW = clog2_min1(M);

  logic [M-1:0][N-1:0] staging_q;
  logic [M-1:0][N-1:0] active_q;
  logic [IW-1:0]       slice_q;
  logic                pending_q;
  logic                ack_q;
  logic                copy_now;
  logic [M-1:0]        slice_bits;

  // The downstream adder counts its own frame, so the bank may only swap
  // on the last slice of a frame; the next cycle is slice 0 with new data.
  assign copy_now = (slice_q == IW'(N - 1)) && pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slice_q   <= '0;
      staging_q <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      slice_q <= slice_q + IW'(1);
      ack_q   <= copy_now;

      // A commit coinciding with the copy is absorbed: that copy already
      // satisfies it, so pending simply clears.
      if (copy_now) begin
        active_q  <= staging_q;
        pending_q <= 1'b0;
      end else if (bus.commit) begin
        pending_q <= 1'b1;
      end

      // Address decode by compare: addresses >= M match no word and drop.
      // The copy above reads pre-edge staging, so a same-edge write misses it.
      for (int j = 0; j < M; j++) begin
        if (bus.wr_en && (bus.wr_addr == AW'(j))) begin
          staging_q[j] <= bus.wr_data;
        end
      end
    end
  end

  bit_slice_mux #(.M(M), .N(N)) u_mux (
    .words (active_q),
    .idx   (slice_q),
    .bits  (slice_bits)
  );

  assign bus.data_bits      = slice_bits;
  assign bus.slice_idx      = slice_q;
  assign bus.frame_start    = (slice_q == '0);
  assign bus.commit_pending = pending_q;
  assign bus.commit_ack     = ack_q;

endmodule

// File: tb/tb_bit_slice_transmitter.sv
// Self-checking bench for bit_slice_transmitter: directed test-plan scenarios plus random traffic.
// A frame-level reference model pushes the expected outputs every cycle; a monitor pops and compares.
// The monitor also rebuilds the adder's per-frame sum from the observed slices.
module tb_bit_slice_transmitter;
  import bit_slice_transmitter_pkg::*;

  localparam int M  = DEF_M;
  localparam int N  = DEF_N;
  localparam int AW = clog2_min1(M);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_slice_transmitter_if #(.M(M), .N(N)) bus ();

  bit_slice_transmitter #(.M(M), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [M-1:0] bits;
    int           slice;
    bit           fs;
    bit           pend;
    bit           ack;
    bit           has_sum;
    longint       sum;
  } exp_t;

  exp_t        exp_q[$];
  longint      m_stage[M];
  longint      m_act[M];
  int          m_cycles = 0;  // cycles since reset release
  bit          m_pend = 0;
  bit          m_ack = 0;

  always @(posedge clk) begin
    exp_t e;
    longint tot;
    int sl;
    if (rst) begin
      m_cycles = 0;
      m_pend   = 0;
      m_ack    = 0;
      for (int j = 0; j < M; j++) begin
        m_stage[j] = 0;
        m_act[j]   = 0;
      end
    end else begin
      bit last;
      last  = (m_cycles % N) == N - 1;
      m_ack = last && m_pend;
      if (m_ack) begin
        for (int j = 0; j < M; j++) m_act[j] = m_stage[j];
        m_pend = 0;
      end else if (bus.commit) begin
        m_pend = 1;
      end
      if (bus.wr_en && int'(bus.wr_addr) < M)
        m_stage[int'(bus.wr_addr)] = longint'(bus.wr_data);
      m_cycles++;
    end
    sl  = m_cycles % N;
    tot = 0;
    for (int j = 0; j < M; j++) begin
      e.bits[j] = m_act[j][sl];
      tot += m_act[j];
    end
    e.slice   = sl;
    e.fs      = (sl == 0);
    e.pend    = m_pend;
    e.ack     = m_ack;
    e.has_sum = (sl == N - 1);
    e.sum     = tot;
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  longint acc      = 0;
  longint last_sum = -1;
  int     ack_cnt  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data_bits",      longint'(bus.data_bits),      longint'(e.bits));
      chk("slice_idx",      longint'(bus.slice_idx),      longint'(e.slice));
      chk("frame_start",    longint'(bus.frame_start),    longint'(e.fs));
      chk("commit_pending", longint'(bus.commit_pending), longint'(e.pend));
      chk("commit_ack",     longint'(bus.commit_ack),     longint'(e.ack));
      if (bus.commit_ack === 1'b1) ack_cnt++;
      if (bus.slice_idx == 0) acc = 0;
      acc += longint'($countones(bus.data_bits)) << bus.slice_idx;
      if (e.has_sum) begin
        chk("frame_sum", acc, e.sum);
        last_sum = acc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [N-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
  endtask

  task automatic wait_slice(input int s);
    for (int i = 0; i < 2 * N && int'(bus.slice_idx) != s; i++) step();
    if (int'(bus.slice_idx) != s) begin
      n_fail++;
      $display("FAIL wait_slice: timeout waiting for slice %0d, at %0d", s, bus.slice_idx);
    end
  endtask

  initial begin
    int acks_before;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.commit  = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("reset_slice",  longint'(bus.slice_idx),   0);
    chk("reset_fstart", longint'(bus.frame_start), 1);
    rst = 1'b0;

    // Idle: two full frames of zero data
    repeat (2 * N) step();

    // All ones, commit in slice 5
    for (int j = 0; j < M; j++) wr(j, '1);
    wait_slice(5);
    do_commit();
    wait_slice(0);
    chk("ones_ack",  longint'(bus.commit_ack), 1);
    chk("ones_bits", longint'(bus.data_bits),  64'hFFFF_FFFF);
    step();
    wait_slice(0);
    chk("ones_sum", last_sum, 64'h1F_FFFF_FFE0);

    // word j = j
    for (int j = 0; j < M; j++) wr(j, N'(j));
    wait_slice(10);
    do_commit();
    wait_slice(0);
    chk("ramp_s0", longint'(bus.data_bits), 64'hAAAA_AAAA);
    wait_slice(4);
    chk("ramp_s4", longint'(bus.data_bits), 64'hFFFF_0000);
    wait_slice(5);
    chk("ramp_s5", longint'(bus.data_bits), 0);
    wait_slice(0);
    chk("ramp_sum", last_sum, 496);

    // Commit in last slice with pending low: takes effect one frame later
    wr(0, '1);
    wait_slice(N - 1);
    do_commit();
    chk("late_pend",  longint'(bus.commit_pending), 1);
    chk("late_ack0",  longint'(bus.commit_ack),     0);
    chk("late_old",   longint'(bus.data_bits[0]),   0);
    step();
    wait_slice(0);
    chk("late_ack1",  longint'(bus.commit_ack),   1);
    chk("late_new",   longint'(bus.data_bits[0]), 1);

    // Write on the copy edge misses the copy
    wait_slice(10);
    do_commit();
    wait_slice(N - 1);
    wr(1, 32'hDEAD_BEEE);
    chk("edge_ack",  longint'(bus.commit_ack),   1);
    chk("edge_old",  longint'(bus.data_bits[1]), 1);
    wait_slice(3);
    do_commit();
    wait_slice(0);
    chk("edge_new",  longint'(bus.data_bits[1]), 0);

    // Double write to word 3 within one frame; last wins
    step();
    wr(3, 32'h0000_0001);
    wr(3, 32'h8000_0000);
    do_commit();
    wait_slice(0);
    chk("dbl_s0", longint'(bus.data_bits[3]), 0);
    wait_slice(N - 1);
    chk("dbl_s31", longint'(bus.data_bits[3]), 1);

    // Random traffic
    for (int i = 0; i < 1200; i++) begin
      bus.wr_en   = ($urandom_range(0, 99) < 30);
      bus.wr_addr = AW'($urandom_range(0, M - 1));
      bus.wr_data = $urandom;
      bus.commit  = ($urandom_range(0, 99) < 6);
      step();
    end
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;

    // Reset mid-frame with a commit pending: no ack must ever follow
    wr(7, '1);
    wait_slice(5);
    do_commit();
    wait_slice(17);
    rst = 1'b1;
    step();
    chk("rst_pend",  longint'(bus.commit_pending), 0);
    chk("rst_bits",  longint'(bus.data_bits),      0);
    chk("rst_slice", longint'(bus.slice_idx),      0);
    step();
    rst = 1'b0;
    acks_before = ack_cnt;
    repeat (2 * N + 2) step();
    chk("rst_no_ack", longint'(ack_cnt), longint'(acks_before));
    chk("rst_zero_sum", last_sum, 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t limit 2000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
